// File: rtl/ap_seq_pkg.sv
// Shared encodings for the AP/data line sequencer: opcodes, FSM states,
// control-pin decode helpers and default parameter values.
package ap_seq_pkg;

    localparam int DEFAULT_COUNT_W        = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        OP_DATA_INC = 3'd0,
        OP_DATA_DEC = 3'd1,
        OP_AP_INC   = 3'd2,
        OP_AP_DEC   = 3'd3,
        OP_DATA_CLR = 3'd4,
        OP_AP_CLR   = 3'd5,
        OP_DATA_CIN = 3'd6,
        OP_TEST     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_TEST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic ap_req;
        logic data_req;
        logic dec;
        logic zero;
        logic cin;
    } line_pins_t;

    function automatic line_pins_t op_pins(input op_e op);
        line_pins_t p;
        p = '0;
        case (op)
            OP_DATA_INC: p.data_req = 1'b1;
            OP_DATA_DEC: begin p.data_req = 1'b1; p.dec  = 1'b1; end
            OP_AP_INC:   p.ap_req   = 1'b1;
            OP_AP_DEC:   begin p.ap_req   = 1'b1; p.dec  = 1'b1; end
            OP_DATA_CLR: begin p.data_req = 1'b1; p.zero = 1'b1; end
            OP_AP_CLR:   begin p.ap_req   = 1'b1; p.zero = 1'b1; end
            OP_DATA_CIN: begin p.data_req = 1'b1; p.cin  = 1'b1; end
            OP_TEST:     p = '0;
            default:     p = '0;
        endcase
        return p;
    endfunction

    function automatic logic is_data_op(input op_e op);
        return (op == OP_DATA_INC) || (op == OP_DATA_DEC) ||
               (op == OP_DATA_CLR) || (op == OP_DATA_CIN);
    endfunction

    // Only the plain inc/dec ops can be repeated; everything else runs once.
    function automatic logic is_repeat_op(input op_e op);
        return (op == OP_DATA_INC) || (op == OP_DATA_DEC) ||
               (op == OP_AP_INC)   || (op == OP_AP_DEC);
    endfunction

endpackage

// File: rtl/ap_line_sequencer.sv
// Sequencer issuing single-cycle request pulses to the AP/data line and waiting
// for LineReady after each one. Optional macro AP_SEQ_REPEAT_EN enables repeat counts.
module ap_line_sequencer
    import ap_seq_pkg::*;
#(
    parameter int COUNT_W        = DEFAULT_COUNT_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               CmdValid,
    input  logic [2:0]         CmdOp,
    input  logic [COUNT_W-1:0] CmdCount,
    output logic               CmdReady,
    output logic               ApRequest,
    output logic               DataRequest,
    output logic               Dec,
    output logic               Zero,
    output logic               Cin,
    input  logic               LineReady,
    input  logic               DataZero,
    input  logic               ApZero,
    output logic               Busy,
    output logic               Done,
    output logic               ZeroFlag,
    output logic               Err
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state,     w_state_nxt;
    op_e              r_op,        w_op_nxt;
    logic [TMR_W-1:0] r_timer,     w_timer_nxt;
    line_pins_t       r_pins,      w_pins_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_zero_flag, w_zero_flag_nxt;
    logic             r_err,       w_err_nxt;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_unused_ap_zero;
    op_e              w_cmd_op;

    assign w_cmd_op         = op_e'(CmdOp);
    assign w_cmd_ready      = (r_state == ST_IDLE) & LineReady & ~r_err;
    assign w_accept         = CmdValid & w_cmd_ready;
    assign w_unused_ap_zero = ApZero;

`ifdef AP_SEQ_REPEAT_EN
    logic [COUNT_W-1:0] r_count, w_count_nxt, w_count_dec, w_count_load;

    // Saturating decrement keeps the count from wrapping below zero.
    assign w_count_dec  = (r_count == '0) ? '0 : (r_count - COUNT_W'(1));
    assign w_last       = (w_count_dec == '0);
    assign w_count_load = (is_repeat_op(w_cmd_op) && (CmdCount != '0)) ? CmdCount : COUNT_W'(1);

    // Remaining-issue counter register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Remaining-issue counter next value
    always_comb begin
        w_count_nxt = r_count;
        if ((r_state == ST_IDLE) && w_accept) begin
            w_count_nxt = w_count_load;
        end else if ((r_state == ST_WAIT) && LineReady) begin
            w_count_nxt = w_count_dec;
        end else if (r_state == ST_DONE) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count;
        end
    end
`else
    logic [COUNT_W-1:0] w_unused_cmd_count;

    assign w_unused_cmd_count = CmdCount;
    assign w_last             = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_timer_nxt     = r_timer;
        w_pins_nxt      = '0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_zero_flag_nxt = r_zero_flag;
        w_err_nxt       = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = w_cmd_op;
                    w_busy_nxt  = 1'b1;
                    w_timer_nxt = '0;
                    if (w_cmd_op == OP_TEST) begin
                        w_state_nxt = ST_TEST;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_pins_nxt  = op_pins(w_cmd_op);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_timer_nxt = '0;
            end
            ST_WAIT: begin
                if (LineReady) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        if (is_data_op(r_op)) begin
                            w_zero_flag_nxt = DataZero;
                        end else begin
                            w_zero_flag_nxt = r_zero_flag;
                        end
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_pins_nxt  = op_pins(r_op);
                        w_timer_nxt = '0;
                    end
                end else if (r_timer == TMR_LAST) begin
                    // Line never answered: flag a sticky error and finish the command.
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_TEST: begin
                w_zero_flag_nxt = DataZero;
                w_done_nxt      = 1'b1;
                w_state_nxt     = ST_DONE;
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_op        <= OP_DATA_INC;
            r_timer     <= '0;
            r_pins      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_zero_flag <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_op        <= w_op_nxt;
            r_timer     <= w_timer_nxt;
            r_pins      <= w_pins_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_zero_flag <= w_zero_flag_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign CmdReady    = w_cmd_ready;
    assign ApRequest   = r_pins.ap_req;
    assign DataRequest = r_pins.data_req;
    assign Dec         = r_pins.dec;
    assign Zero        = r_pins.zero;
    assign Cin         = r_pins.cin;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign ZeroFlag    = r_zero_flag;
    assign Err         = r_err;

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Self-checking bench for ap_line_sequencer: random commands against a
// behavioural model of issue counts, pin patterns, latency and status flags.
module tb_ap_line_sequencer;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       CmdValid;
    logic [2:0] CmdOp;
    logic [7:0] CmdCount;
    logic       CmdReady;
    logic       ApRequest, DataRequest, Dec, Zero, Cin;
    logic       LineReady, DataZero, ApZero;
    logic       Busy, Done, ZeroFlag, Err;

    int   checks = 0;
    int   errors = 0;
    logic zf_model = 1'b0;

    ap_line_sequencer #(.COUNT_W(8), .TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdCount(CmdCount),
        .CmdReady(CmdReady), .ApRequest(ApRequest), .DataRequest(DataRequest), .Dec(Dec),
        .Zero(Zero), .Cin(Cin), .LineReady(LineReady), .DataZero(DataZero), .ApZero(ApZero),
        .Busy(Busy), .Done(Done), .ZeroFlag(ZeroFlag), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Pin pattern {ap, data, dec, zero, cin} from the opcode table.
    function automatic logic [4:0] pins_ref(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b01000;
            3'd1:    return 5'b01100;
            3'd2:    return 5'b10000;
            3'd3:    return 5'b10100;
            3'd4:    return 5'b01010;
            3'd5:    return 5'b10010;
            3'd6:    return 5'b01001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int issues_ref(input logic [2:0] op, input logic [7:0] cnt);
        if (op == 3'd7) return 0;
`ifdef AP_SEQ_REPEAT_EN
        if (op < 3'd4) return (cnt == 8'd0) ? 1 : int'(cnt);
`endif
        return 1;
    endfunction

    // Runs one command; the line answers d cycles (d in [d_min,d_max]) into each WAIT.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] cnt, input int d_min,
                           input int d_max, input logic dz, input string tag, output int busy_n);
        int pulses, done_n, done_cyc, exp_lat, rem, cyc, d, stray, n_exp;
        logic [4:0] got;
        bit finished;
        n_exp = issues_ref(op, cnt);
        exp_lat = (op == 3'd7) ? 2 : 1;
        pulses = 0; done_n = 0; done_cyc = -1; rem = 0; cyc = 0; stray = 0; busy_n = 0;
        finished = 1'b0;
        @(negedge Clk);
        CmdValid = 1'b1; CmdOp = op; CmdCount = cnt; DataZero = dz; LineReady = 1'b1;
        #1;
        checks++;
        if (CmdReady !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready: got %b expected 1", tag, CmdReady);
        end
        @(posedge Clk);
        while (!finished && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            CmdValid = 1'b0;
            got = {ApRequest, DataRequest, Dec, Zero, Cin};
            if (ApRequest || DataRequest) begin
                pulses++;
                checks++;
                if (got !== pins_ref(op)) begin
                    errors++; $display("FAIL %s pins: got %b expected %b", tag, got, pins_ref(op));
                end
                d = $urandom_range(d_max, d_min);
                exp_lat += d + 2;
                rem = d;
                LineReady = 1'b0;
            end else begin
                if (got !== 5'b00000) stray++;
                if (rem > 0) begin
                    rem--;
                    LineReady = 1'b0;
                end else begin
                    LineReady = 1'b1;
                end
            end
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end else if (done_n > 0) begin
                finished = 1'b1;
            end
        end
        if ((op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6) || (op == 3'd7))
            zf_model = dz;
        checks++;
        if (!finished) begin errors++; $display("FAIL %s finish: no Done within %0d cycles", tag, cyc); end
        checks++;
        if (pulses != n_exp) begin errors++; $display("FAIL %s pulses: got %0d expected %0d", tag, pulses, n_exp); end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", tag, done_n); end
        checks++;
        if (done_cyc != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, done_cyc, exp_lat); end
        checks++;
        if (busy_n != exp_lat) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, exp_lat); end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL %s stray_pins: got %0d expected 0", tag, stray); end
        checks++;
        if (ZeroFlag !== zf_model) begin errors++; $display("FAIL %s zero_flag: got %b expected %b", tag, ZeroFlag, zf_model); end
        checks++;
        if (Err !== 1'b0) begin errors++; $display("FAIL %s err: got %b expected 0", tag, Err); end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; CmdValid = 1'b0; CmdOp = 3'd0; CmdCount = 8'd0;
        LineReady = 1'b1; DataZero = 1'b0; ApZero = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({ApRequest, DataRequest, Dec, Zero, Cin, Busy, Done, ZeroFlag, Err} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0",
                               {ApRequest, DataRequest, Dec, Zero, Cin, Busy, Done, ZeroFlag, Err});
        end
        checks++;
        if (CmdReady !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_hi: got %b expected 1", CmdReady); end
        LineReady = 1'b0;
        #1;
        checks++;
        if (CmdReady !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_lo: got %b expected 0", CmdReady); end
        @(negedge Clk);
        Rst_n = 1'b1; LineReady = 1'b1;
        zf_model = 1'b0;
    endtask

    task automatic test_not_ready();
        int bad = 0;
        @(negedge Clk);
        LineReady = 1'b0; CmdValid = 1'b1; CmdOp = 3'd2; CmdCount = 8'd3;
        repeat (6) begin
            @(negedge Clk);
            if (CmdReady !== 1'b0 || Busy !== 1'b0 || ApRequest !== 1'b0 || DataRequest !== 1'b0) bad++;
        end
        CmdValid = 1'b0;
        @(negedge Clk);
        LineReady = 1'b1;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL not_ready: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_repeat_data_inc();
        int busy_n, busy_exp;
`ifdef AP_SEQ_REPEAT_EN
        busy_exp = 10;
`else
        busy_exp = 4;
`endif
        run_cmd(3'd0, 8'd3, 1, 1, 1'b0, "data_inc_x3", busy_n);
        checks++;
        if (busy_n != busy_exp) begin errors++; $display("FAIL data_inc_x3_busy: got %0d expected %0d", busy_n, busy_exp); end
    endtask

    task automatic test_ap_dec_single();
        int busy_n;
        run_cmd(3'd3, 8'd0, 0, 0, 1'b0, "ap_dec_once", busy_n);
    endtask

    task automatic test_clear_and_test();
        int busy_n;
        run_cmd(3'd4, 8'd9, 0, 2, 1'b1, "data_clr", busy_n);
        run_cmd(3'd7, 8'd9, 0, 0, 1'b1, "test_op", busy_n);
        run_cmd(3'd7, 8'd0, 0, 0, 1'b0, "test_op_zero0", busy_n);
    endtask

    task automatic test_no_repeat_dec();
        int busy_n;
        run_cmd(3'd1, 8'd7, 0, 1, 1'b1, "data_dec_x7", busy_n);
    endtask

    task automatic test_count_max();
        int busy_n;
        run_cmd(3'd0, 8'hFF, 0, 0, 1'b0, "count_max", busy_n);
    endtask

    task automatic test_random();
        int busy_n;
        logic [2:0] op;
        logic [7:0] cnt;
        for (int i = 0; i < 25; i++) begin
            op  = 3'($urandom_range(7, 0));
            cnt = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(6, 0));
            run_cmd(op, cnt, 0, $urandom_range(5, 0), 1'($urandom_range(1, 0)), "random", busy_n);
        end
    endtask

    task automatic test_reset_mid_wait();
        int req_n = 0;
        int busy_n;
        @(negedge Clk);
        CmdValid = 1'b1; CmdOp = 3'd2; CmdCount = 8'd5; LineReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0; LineReady = 1'b0;
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({ApRequest, DataRequest, Dec, Zero, Cin, Busy, Done, ZeroFlag, Err, CmdReady} !== 10'd0) begin
            errors++; $display("FAIL reset_mid_wait: got %b expected 0",
                               {ApRequest, DataRequest, Dec, Zero, Cin, Busy, Done, ZeroFlag, Err, CmdReady});
        end
        zf_model = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1; LineReady = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (ApRequest !== 1'b0 || DataRequest !== 1'b0 || Busy !== 1'b0) req_n++;
        end
        checks++;
        if (req_n != 0) begin errors++; $display("FAIL no_reissue: got %0d active cycles expected 0", req_n); end
        run_cmd(3'd2, 8'd2, 0, 2, 1'b0, "after_reset", busy_n);
    endtask

    task automatic test_timeout();
        int cyc = 0, issue_cyc = -1, done_cyc = -1, pulses = 0, bad = 0;
        @(negedge Clk);
        CmdValid = 1'b1; CmdOp = 3'd6; CmdCount = 8'd0; LineReady = 1'b1;
        @(posedge Clk);
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            CmdValid = 1'b0; LineReady = 1'b0;
            if (DataRequest === 1'b1) begin
                pulses++;
                if (issue_cyc < 0) issue_cyc = cyc;
            end
            if (Done === 1'b1) done_cyc = cyc;
        end
        checks++;
        if (done_cyc - issue_cyc != 17) begin
            errors++; $display("FAIL timeout_latency: got %0d expected 17", done_cyc - issue_cyc);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", pulses); end
        checks++;
        if (Err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", Err); end
        LineReady = 1'b1; CmdValid = 1'b1; CmdOp = 3'd0; CmdCount = 8'd1;
        repeat (10) begin
            @(negedge Clk);
            if (CmdReady !== 1'b0 || Busy !== 1'b0 || DataRequest !== 1'b0 || Err !== 1'b1) bad++;
        end
        CmdValid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL err_blocks_cmds: got %0d bad cycles expected 0", bad); end
        checks++;
        if (ZeroFlag !== zf_model) begin errors++; $display("FAIL timeout_zero_flag: got %b expected %b", ZeroFlag, zf_model); end
    endtask

    initial begin
        test_reset();
        test_not_ready();
        test_repeat_data_inc();
        test_ap_dec_single();
        test_clear_and_test();
        test_no_repeat_dec();
        test_count_max();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
